prog_rom: RTL and testbench

PROG_ROM -- requirements
Module: prog_rom

---
 rtl/prog_rom.sv | 195 +++++++++++++++++++
 tb/tb_prog_rom.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prog_rom.sv
// Byte-addressed program ROM with a bus write port, data read port, fetch port and byte-stream loader.
// Define PROG_ROM_CLEAR_ON_RESET_EN to zero the whole array with a CLEAR sweep after every reset.
module prog_rom #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [DATA_W/8-1:0]   wr_strb_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic [ADDR_W-1:0]     pc_addr_i,
    output logic [DATA_W-1:0]     ins_o,
    input  logic                  ld_start_i,
    input  logic                  ld_valid_i,
    input  logic                  ld_last_i,
    input  logic [7:0]            ld_byte_i,
    output logic                  ld_ready_o,
    output logic                  ld_done_o,
    output logic                  ld_err_o,
    output logic                  busy_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [CW-1:0]    LAST_LANE = CW'(BYTES - 1);

`ifdef PROG_ROM_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;
    localparam state_t RST_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, LOAD} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    function automatic logic in_rng(input logic [ADDR_W-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              we;
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] wdata;
    logic [BYTES-1:0]  wstrb;
    logic [DATA_W-1:0] ld_word;
    logic [DATA_W-1:0] rd_next, ins_next;

    assign ld_ready_o = (state_q == LOAD);
    assign busy_o     = (state_q != IDLE);
    assign ld_done_o  = done_q;
    assign ld_err_o   = err_q;
    assign ld_word    = asm_q | (DATA_W'(ld_byte_i) << {cnt_q, 3'b000});

    // Single write port shared by bus, loader and clear sweep; the state decides the owner.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        err_d   = err_q;
        done_d  = 1'b0;
        we      = 1'b0;
        widx    = ptr_q;
        wdata   = '0;
        wstrb   = '0;
        case (state_q)
            IDLE: begin
                if (wr_en_i && in_rng(wr_addr_i)) begin
                    we    = 1'b1;
                    widx  = idx(wr_addr_i);
                    wdata = wr_data_i;
                    wstrb = wr_strb_i;
                end
                if (ld_start_i) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    asm_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (ld_valid_i) begin
                    asm_d = ld_word;
                    cnt_d = cnt_q + 1'b1;
                    if (ld_last_i || cnt_q == LAST_LANE) begin
                        we    = 1'b1;
                        wdata = ld_word;
                        wstrb = '1;
                        asm_d = '0;
                        cnt_d = '0;
                        if (ld_last_i) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (ptr_q == LAST_IDX) begin
                            // Array full with no end marker: stop rather than wrap.
                            state_d = IDLE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
            end
`ifdef PROG_ROM_CLEAR_ON_RESET_EN
            CLEAR: begin
                we    = 1'b1;
                wstrb = '1;
                if (ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < BYTES; l++) begin
                if (wstrb[l]) mem[widx][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    // Write-first: lanes being written this cycle bypass the array on both read ports.
    always_comb begin
        rd_next = '0;
        if (in_rng(rd_addr_i)) begin
            rd_next = mem[idx(rd_addr_i)];
            for (int l = 0; l < BYTES; l++) begin
                if (we && wstrb[l] && widx == idx(rd_addr_i)) rd_next[8*l +: 8] = wdata[8*l +: 8];
            end
        end
    end

    always_comb begin
        ins_next = '0;
        if (in_rng(pc_addr_i)) begin
            ins_next = mem[idx(pc_addr_i)];
            for (int l = 0; l < BYTES; l++) begin
                if (we && wstrb[l] && widx == idx(pc_addr_i)) ins_next[8*l +: 8] = wdata[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
            ins_o     <= '0;
        end else begin
            rd_data_o <= rd_next;
            ins_o     <= busy_o ? '0 : ins_next;
        end
    end
endmodule

// File: tb/tb_prog_rom.sv
// Randomized bench for prog_rom (DEPTH=16) against a word-array reference model.
module tb_prog_rom;
    localparam int DW = 32, DEPTH = 16, AW = 32;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          wr_en_i = 0;
    logic [AW-1:0] wr_addr_i = 0, rd_addr_i = 0, pc_addr_i = 0;
    logic [DW-1:0] wr_data_i = 0;
    logic [3:0]    wr_strb_i = 0;
    logic [DW-1:0] rd_data_o, ins_o;
    logic          ld_start_i = 0, ld_valid_i = 0, ld_last_i = 0;
    logic [7:0]    ld_byte_i = 0;
    logic          ld_ready_o, ld_done_o, ld_err_o, busy_o;

    prog_rom #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .pc_addr_i(pc_addr_i), .ins_o(ins_o),
        .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_last_i(ld_last_i), .ld_byte_i(ld_byte_i),
        .ld_ready_o(ld_ready_o), .ld_done_o(ld_done_o), .ld_err_o(ld_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0;
    logic [31:0] ref_mem [DEPTH];

    always @(negedge clk) if (ld_done_o) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return (a < DEPTH * 4) ? ref_mem[a / 4] : 32'h0;
    endfunction

    // One bus cycle: drive at negedge, apply write to the model, check both ports a cycle later.
    task automatic bus_cycle(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                             input logic [3:0] ws, input logic [31:0] ra, input logic [31:0] pa);
        logic [31:0] er, ei;
        wr_en_i = w; wr_addr_i = wa; wr_data_i = wd; wr_strb_i = ws;
        rd_addr_i = ra; pc_addr_i = pa;
        if (w && wa < DEPTH * 4)
            for (int l = 0; l < 4; l++) if (ws[l]) ref_mem[wa / 4][8*l +: 8] = wd[8*l +: 8];
        er = ref_rd(ra); ei = ref_rd(pa);
        @(negedge clk);
        wr_en_i = 0;
        chk("rd_data", rd_data_o, er);
        chk("ins", ins_o, ei);
    endtask

    task automatic readback();
        for (int k = 0; k < DEPTH; k++) bus_cycle(0, 0, 0, 0, k * 4 + $urandom_range(0, 3), (DEPTH - 1 - k) * 4);
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 4) == 0) return $urandom_range(DEPTH * 4, 255) | (($urandom_range(0, 1)) << 31);
        return $urandom_range(0, DEPTH * 4 - 1);
    endfunction

    task automatic do_reset();
        int n;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_rd", rd_data_o, 0);
        chk("rst_ins", ins_o, 0);
        chk("rst_ready", {31'b0, ld_ready_o}, 0);
        chk("rst_done", {31'b0, ld_done_o}, 0);
        chk("rst_err", {31'b0, ld_err_o}, 0);
        ld_valid_i = 0; ld_last_i = 0; ld_start_i = 0; wr_en_i = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        n = 0;
        while (busy_o && n < 100) begin @(negedge clk); n++; end
`ifdef PROG_ROM_CLEAR_ON_RESET_EN
        chk("clr_busy_cycles", n, 16);
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 0;
        bus_cycle(0, 0, 0, 0, 32'h3C, 32'h3C);
        chk("clr_0x3c", rd_data_o, 0);
`else
        chk("busy_after_rst", n, 0);
`endif
    endtask

    // Stream bytes into the loader; last_at < 0 means no end marker.
    task automatic load_run(input logic [7:0] bytes[$], input int last_at, input bit gaps);
        int i, cyc, d0, n_acc;
        bit err;
        err   = (last_at < 0) || (last_at >= DEPTH * 4);
        n_acc = err ? DEPTH * 4 : last_at + 1;
        d0 = done_cnt;
        ld_start_i = 1;
        @(negedge clk);
        ld_start_i = 0;
        chk("ld_ready_on", {31'b0, ld_ready_o}, 1);
        i = 0; cyc = 0;
        while (i < bytes.size() && cyc < 1000) begin
            if (!ld_ready_o) break;
            if (cyc == 1) chk("ins_busy", ins_o, 0);
            wr_en_i = 1; wr_addr_i = $urandom_range(0, DEPTH * 4 - 1); wr_data_i = $urandom; wr_strb_i = 4'hF;
            pc_addr_i = $urandom_range(0, DEPTH * 4 - 1);
            ld_valid_i = !(gaps && $urandom_range(0, 2) == 0);
            ld_byte_i  = bytes[i];
            ld_last_i  = (i == last_at);
            @(negedge clk);
            if (ld_valid_i) i++;
            cyc++;
        end
        wr_en_i = 0; ld_valid_i = 0; ld_last_i = 0;
        @(negedge clk); @(negedge clk);
        chk("ld_accepted", i, n_acc);
        chk("ld_done_pulses", done_cnt - d0, 1);
        chk("ld_err", {31'b0, ld_err_o}, {31'b0, err});
        chk("ld_ready_off", {31'b0, ld_ready_o}, 0);
        for (int w = 0; w < (n_acc + 3) / 4; w++) ref_mem[w] = 0;
        for (int j = 0; j < n_acc; j++) ref_mem[j / 4][8*(j % 4) +: 8] = bytes[j];
    endtask

    initial begin
        logic [7:0] q[$];
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 0;
        do_reset();

        for (int k = 0; k < DEPTH; k++) bus_cycle(1, k * 4, $urandom, 4'hF, k * 4, 0);

        bus_cycle(1, 32'h8, 0, 4'hF, 0, 0);
        bus_cycle(1, 32'h8, 32'hAABBCCDD, 4'b0101, 0, 0);
        bus_cycle(0, 0, 0, 0, 32'h8, 32'h8);
        chk("strb_merge", rd_data_o, 32'h00BB00DD);
        bus_cycle(1, 32'h4, 32'h12345678, 4'hF, 32'h4, 32'h4);
        chk("wr_first_rd", rd_data_o, 32'h12345678);
        chk("wr_first_ins", ins_o, 32'h12345678);
        bus_cycle(1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h40, 32'h0);
        chk("oor_read", rd_data_o, 0);

        for (int c = 0; c < 200; c++)
            bus_cycle($urandom_range(0, 1), rnd_addr(), $urandom, 4'($urandom), rnd_addr(), rnd_addr());

        q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h05};
        load_run(q, 5, 0);
        bus_cycle(0, 0, 0, 0, 32'h0, 32'h4);
        chk("ld_word0", rd_data_o, 32'h00000013);
        chk("ld_word1", ins_o, 32'h00000593);
        readback();

        for (int r = 0; r < 3; r++) begin
            int len;
            len = $urandom_range(1, 40);
            q = {};
            for (int j = 0; j < len; j++) q.push_back(8'($urandom));
            load_run(q, len - 1, 1);
            readback();
        end

        q = {};
        for (int j = 0; j < 68; j++) q.push_back(8'($urandom));
        load_run(q, -1, 1);
        chk("ovf_busy", {31'b0, busy_o}, 0);
        bus_cycle(0, 0, 0, 0, 32'h0, 32'h3C);
        chk("ovf_word0", rd_data_o, {q[3], q[2], q[1], q[0]});
        chk("ovf_word15", ins_o, {q[63], q[62], q[61], q[60]});
        readback();

        ld_start_i = 1;
        @(negedge clk);
        ld_start_i = 0;
        for (int j = 0; j < 2; j++) begin
            ld_valid_i = 1; ld_byte_i = 8'h11 * (j + 1);
            @(negedge clk);
        end
        ld_valid_i = 0;
        do_reset();
        chk("abort_ready", {31'b0, ld_ready_o}, 0);
        readback();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
